// File: rtl/conv_pkg.sv
// Shared definitions for the convolution result streaming path.
// Provides the streamer FSM state encoding, default datapath geometry
// and the AXI4-Stream keep mask used for fully populated beats.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_KEEP_W      = DEF_DATA_WIDTH / 8;

    // Every byte of a result word is meaningful.
    localparam logic [DEF_KEEP_W-1:0] KEEP_ALL_ONES = {DEF_KEEP_W{1'b1}};

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word fall-through FIFO for convolution results.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous clear (empties the FIFO)
//   push, din       write request and data (ignored when full unless popping)
//   pop, dout       read request and head-of-queue word (valid when !empty)
//   full, empty     occupancy flags
//   level           number of stored words
module result_fifo
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      din,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_r;
    logic [ADDR_W-1:0]     rd_ptr_r;
    logic [LVL_W-1:0]      level_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full  = (level_r == LVL_W'(DEPTH));
    assign empty = (level_r == {LVL_W{1'b0}});
    assign level = level_r;
    // Head word comes straight from the storage registers, so it is stable
    // for as long as the read pointer does not move.
    assign dout  = mem_r[rd_ptr_r];

    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign do_push_s = push && (!full || pop);
    assign do_pop_s  = pop && !empty;

    // Storage array write port; contents need no reset since level gates reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/conv_result_streamer.sv
// Captures convolution results (cSum on each rising edge of cReady) into a
// result FIFO and streams them out on an AXI4-Stream master port, marking
// the final beat of each frame with m_axis_last.
// Ports:
//   axi_clk, axi_reset_n    clock, asynchronous active-low reset
//   enable, soft_reset      control-register enable and synchronous clear
//   img_width, img_height   frame geometry used to size the valid window
//   cSum, cReady            result word and result-valid level
//   m_axis_*                AXI4-Stream master (valid/data/ready/last/keep)
//   overflow                sticky: a result was dropped on a full FIFO
//   frame_done              one-cycle pulse after the last beat handshakes
//   fifo_level              current FIFO occupancy
module conv_result_streamer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int FIFO_DEPTH  = 16,
    parameter int DIM_WIDTH   = 16
) (
    input  logic                          axi_clk,
    input  logic                          axi_reset_n,
    input  logic                          enable,
    input  logic                          soft_reset,
    input  logic [DIM_WIDTH-1:0]          img_width,
    input  logic [DIM_WIDTH-1:0]          img_height,
    input  logic [DATA_WIDTH-1:0]         cSum,
    input  logic                          cReady,
    output logic                          m_axis_valid,
    output logic [DATA_WIDTH-1:0]         m_axis_data,
    input  logic                          m_axis_ready,
    output logic                          m_axis_last,
    output logic [DATA_WIDTH/8-1:0]       m_axis_keep,
    output logic                          overflow,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W  = 2 * DIM_WIDTH;
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam logic [DIM_WIDTH-1:0] K_DIM = DIM_WIDTH'(KERNEL_SIZE);
    localparam logic [DIM_WIDTH-1:0] K_M1  = DIM_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [KEEP_W-1:0] KEEP_ONES =
        (KEEP_W == DEF_KEEP_W) ? KEEP_W'(KEEP_ALL_ONES) : {KEEP_W{1'b1}};

    state_e              state_r, state_next_s;
    logic                cready_d_r;
    logic [CNT_W-1:0]    total_r, total_s;
    logic [CNT_W-1:0]    in_cnt_r, out_cnt_r;
    logic                overflow_r, frame_done_r;
    logic                latch_total_s, clr_cnt_s;
    logic                push_req_s, accept_s, fifo_push_s, drop_s, pop_s, last_s;
    logic                fifo_full_s, fifo_empty_s;
    logic [DATA_WIDTH-1:0] fifo_dout_s;

    // Valid output window; a dimension smaller than the kernel yields no output.
    always_comb begin
        total_s = {CNT_W{1'b0}};
        if ((img_width >= K_DIM) && (img_height >= K_DIM)) begin
            total_s = CNT_W'(img_width - K_M1) * CNT_W'(img_height - K_M1);
        end else begin
            total_s = {CNT_W{1'b0}};
        end
    end

    assign push_req_s  = enable && (state_r == ST_RUN) && cReady && !cready_d_r;
    // Results beyond the frame window are silently discarded.
    assign accept_s    = push_req_s && (in_cnt_r < total_r);
    assign pop_s       = m_axis_valid && m_axis_ready;
    assign fifo_push_s = accept_s && (!fifo_full_s || pop_s);
    assign drop_s      = accept_s && fifo_full_s && !pop_s;
    assign last_s      = m_axis_valid && (out_cnt_r == (total_r - CNT_W'(1)));

    assign m_axis_valid = !fifo_empty_s;
    // Stale storage is masked so the bus reads zero when idle.
    assign m_axis_data  = m_axis_valid ? fifo_dout_s : {DATA_WIDTH{1'b0}};
    assign m_axis_keep  = m_axis_valid ? KEEP_ONES : {KEEP_W{1'b0}};
    assign m_axis_last  = last_s;
    assign overflow     = overflow_r;
    assign frame_done   = frame_done_r;

    result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (axi_clk),
        .rst_n (axi_reset_n),
        .clr   (soft_reset),
        .push  (fifo_push_s),
        .pop   (pop_s),
        .din   (cSum),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // Frame sequencing: next state plus total-latch and counter-clear strobes.
    always_comb begin
        state_next_s  = state_r;
        latch_total_s = 1'b0;
        clr_cnt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && (total_s != {CNT_W{1'b0}})) begin
                    state_next_s  = ST_RUN;
                    latch_total_s = 1'b1;
                    clr_cnt_s     = 1'b1;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (pop_s && last_s) begin
                    state_next_s = ST_DONE;
                end else if (!enable && fifo_empty_s) begin
                    // Enable dropped mid-frame and everything captured has drained.
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                clr_cnt_s = 1'b1;
                if (enable && (total_s != {CNT_W{1'b0}})) begin
                    state_next_s  = ST_RUN;
                    latch_total_s = 1'b1;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, edge-detect history, frame total and status flags.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_r      <= ST_IDLE;
            cready_d_r   <= 1'b0;
            total_r      <= {CNT_W{1'b0}};
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else if (soft_reset) begin
            state_r      <= ST_IDLE;
            cready_d_r   <= 1'b0;
            total_r      <= {CNT_W{1'b0}};
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cready_d_r   <= cReady;
            if (latch_total_s) begin
                total_r <= total_s;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            // High during the DONE cycle that follows the last-beat handshake.
            frame_done_r <= (state_r == ST_RUN) && pop_s && last_s;
        end
    end

    // Input/output beat counters; in_cnt advances even on dropped results.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            in_cnt_r  <= {CNT_W{1'b0}};
            out_cnt_r <= {CNT_W{1'b0}};
        end else if (soft_reset || clr_cnt_s) begin
            in_cnt_r  <= {CNT_W{1'b0}};
            out_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                in_cnt_r <= in_cnt_r + CNT_W'(1);
            end
            if (pop_s) begin
                out_cnt_r <= out_cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/conv_result_streamer.md
Name: conv_result_streamer

Overview:
Downstream stage of the matrix accelerator. It captures each convolution result (cSum/cReady) into a small FIFO and emits the results on an AXI4-Stream master port. It asserts m_axis_last on the final result of each frame, absorbs backpressure from m_axis_ready, and reports overflow and frame completion to the control register block.

Parameters:
DATA_WIDTH, 32, width of cSum and m_axis_data
KERNEL_SIZE, 3, convolution kernel edge; sets the valid output window size
FIFO_DEPTH, 16, result FIFO entries (power of 2, at least 4)
DIM_WIDTH, 16, width of the image dimension inputs

Ports:
axi_clk  in  1  system clock; all logic on rising edge
axi_reset_n  in  1  asynchronous, active-low reset
enable  in  1  control-register enable; 0 means ignore results and hold in IDLE
soft_reset  in  1  synchronous clear pulse, from the reset register
img_width  in  DIM_WIDTH  frame width in pixels
img_height  in  DIM_WIDTH  frame height in pixels
cSum  in  DATA_WIDTH  accumulated convolution result
cReady  in  1  result-valid level from the accelerator; one result per rising edge
m_axis_valid  out  1  AXI4-S valid
m_axis_data  out  DATA_WIDTH  result word
m_axis_ready  in  1  AXI4-S ready
m_axis_last  out  1  final beat of the frame
m_axis_keep  out  DATA_WIDTH/8  all ones whenever valid, 0 otherwise
overflow  out  1  sticky; a result was dropped because the FIFO was full
frame_done  out  1  one-cycle pulse after the last beat handshakes
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values (axi_reset_n=0, asynchronous): every output is 0. FIFO empty, counters 0, cReady_d=0, state IDLE.
- soft_reset=1: same clear as reset, applied synchronously. It has priority over every other event in the same cycle.
- Frame total: TOTAL = (img_width-KERNEL_SIZE+1)*(img_height-KERNEL_SIZE+1). It is computed with 2*DIM_WIDTH bits and latched on the IDLE->RUN transition.
  - If either dimension is below KERNEL_SIZE, TOTAL=0 and the block stays in IDLE.
- Capture: push when enable=1, state=RUN, cReady=1 and cReady_d=0 (rising edge).
  - Data is written at that clock edge.
  - m_axis_valid is high after the next edge, i.e. one cycle of latency when the FIFO is empty.
  - A cReady level held high produces exactly one push.
- Pop: when m_axis_valid && m_axis_ready. The FIFO uses a registered output (first-word fall-through).
  - While valid && !ready, m_axis_data and m_axis_last must stay stable.
- Full and empty:
  - Push with FIFO full and no pop in the same cycle: the result is dropped, overflow is set to 1, and in_cnt still advances so frame alignment is kept.
  - Simultaneous push and pop when full: both happen; no overflow.
  - Push and pop when empty: the word is written, and valid rises next cycle (no bypass).
- Counters: in_cnt counts pushes and out_cnt counts handshaken beats; both are DIM_WIDTH*2 bits wide.
  - m_axis_last = m_axis_valid && (out_cnt == TOTAL-1).
  - Pushes beyond TOTAL within a frame are ignored and are not counted as overflow.
- FSM:
  - IDLE: go to RUN when enable=1 and TOTAL!=0; latch TOTAL and clear the counters.
  - RUN: stream results. On the last-beat handshake, go to DONE.
  - DONE: frame_done=1 for one cycle, clear the counters, then RUN if enable=1, else IDLE.
  - In RUN, enable 0->1 is not applicable. If enable drops mid-frame: stop capturing, drain the FIFO, then IDLE. m_axis_last is not forced.
- overflow clears only on reset or soft_reset.
- m_axis_data width equals DATA_WIDTH; no truncation or sign handling.

Decomposition:
- Shared package (conv_pkg): the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the default DATA_WIDTH and KERNEL_SIZE, and the keep-all-ones constant.
- One sub-module: result_fifo. It is a synchronous FIFO with parameters DATA_WIDTH and DEPTH, ports push/pop/din/dout/full/empty/level, an asynchronous active-low reset, and a synchronous clear.
- The top level holds the FSM, the edge detector, the counters and the last/overflow logic.

Test Plan:
- W=8, H=8, K=3, enable=1, m_axis_ready=1, 36 cReady pulses with cSum=0..35 -> 36 beats with data 0..35, m_axis_last only on data 35, frame_done pulse one cycle after that beat.
- Same frame with m_axis_ready toggling 1 cycle on / 2 cycles off -> no data lost or reordered; data and last stable while stalled; overflow=0.
- FIFO_DEPTH=16, m_axis_ready=0, 20 pulses with cSum=100..119 -> fifo_level=16, overflow=1. After ready=1 the output is 100..115; in_cnt=20.
- cReady held high for 5 cycles with cSum=7 -> exactly one beat of data 7.
- W=2, H=8, enable=1 -> stays in IDLE, pulses ignored, m_axis_valid=0.
- Mid-frame: axi_reset_n=0 after 10 beats, then re-run the 8x8 frame -> outputs are 0 at reset; the new frame gives 36 beats with last on the 36th; overflow=0.
